// File: rtl/fft8_sequencer_if.sv
// Sample-in / bin-out stream bundle for fft8_sequencer.
// The slave modport is the sequencer's view; master is the producer/consumer side.
interface fft8_sequencer_if #(
  parameter int DW = 11
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_re;
  logic signed [DW-1:0] in_im;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_re;
  logic signed [DW-1:0] out_im;
  logic [2:0]           out_idx;
  logic                 busy;

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_idx, busy
  );

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_idx, busy
  );
endinterface

// File: rtl/fft8_sequencer.sv
// 8-point DIT FFT controller driving one external radix-2 butterfly.
// Loads 8 samples bit-reversed, runs 3 stages x (4 issues + 1 bubble), streams 8 bins.
module fft8_sequencer #(
  parameter int DW = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  fft8_sequencer_if.slave      io,
  output logic [1:0]           bf_k,
  output logic signed [DW-1:0] bf_x0_re,
  output logic signed [DW-1:0] bf_x0_im,
  output logic signed [DW-1:0] bf_x1_re,
  output logic signed [DW-1:0] bf_x1_im,
  input  logic signed [DW:0]   bf_a0_re,
  input  logic signed [DW:0]   bf_a0_im,
  input  logic signed [DW:0]   bf_a1_re,
  input  logic signed [DW:0]   bf_a1_im
);

  typedef enum logic [1:0] {LOAD, RUN, OUT} state_t;

  state_t               state;
  logic [2:0]           n_cnt;
  logic [1:0]           stage;
  logic [2:0]           slot;
  logic [2:0]           out_idx;
  logic                 in_ready;
  logic                 out_valid;
  logic                 busy;

  logic                 issue;
  logic [2:0]           iss_i0;
  logic [2:0]           iss_i1;
  logic                 wb_valid;
  logic [2:0]           wb_i0;
  logic [2:0]           wb_i1;

  logic signed [DW-1:0] store_re [8];
  logic signed [DW-1:0] store_im [8];

  logic                 accept;
  logic                 take;
  logic [2:0]           load_addr;

  logic [1:0]           nx_stage;
  logic [2:0]           nx_slot;
  logic                 nx_issue;
  logic [2:0]           nx_i0;
  logic [2:0]           nx_i1;
  logic [2:0]           nx_half;
  logic [1:0]           nx_k;

  assign accept    = io.in_valid & in_ready;
  assign take      = out_valid & io.out_ready;
  assign load_addr = {n_cnt[0], n_cnt[1], n_cnt[2]};

  // Schedule for the RUN cycle that follows this one; operands are
  // registered so the butterfly sees them exactly in their issue cycle.
  always_comb begin
    nx_stage = stage;
    nx_slot  = slot + 3'd1;
    if (state != RUN) begin
      nx_stage = 2'd0;
      nx_slot  = 3'd0;
    end else if (slot == 3'd4) begin
      nx_stage = stage + 2'd1;
      nx_slot  = 3'd0;
    end
    nx_issue = (nx_slot != 3'd4);
    nx_i0    = '0;
    nx_half  = '0;
    nx_k     = '0;
    case (nx_stage)
      2'd0: begin
        nx_i0   = {nx_slot[1:0], 1'b0};
        nx_half = 3'd1;
      end
      2'd1: begin
        nx_i0   = {nx_slot[1], 1'b0, nx_slot[0]};
        nx_half = 3'd2;
        nx_k    = {nx_slot[0], 1'b0};
      end
      2'd2: begin
        nx_i0   = {1'b0, nx_slot[1:0]};
        nx_half = 3'd4;
        nx_k    = nx_slot[1:0];
      end
      default: nx_issue = 1'b0;
    endcase
    if (!nx_issue) nx_k = '0;
    nx_i1 = nx_i0 | nx_half;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      n_cnt     <= '0;
      stage     <= '0;
      slot      <= '0;
      out_idx   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      bf_k      <= '0;
      issue     <= 1'b0;
      iss_i0    <= '0;
      iss_i1    <= '0;
      wb_valid  <= 1'b0;
      wb_i0     <= '0;
      wb_i1     <= '0;
    end else begin
      wb_valid <= issue;
      wb_i0    <= iss_i0;
      wb_i1    <= iss_i1;
      issue    <= 1'b0;
      bf_k     <= '0;
      case (state)
        LOAD: begin
          if (accept) begin
            n_cnt <= n_cnt + 3'd1;
            if (n_cnt == 3'd7) begin
              state    <= RUN;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              stage    <= nx_stage;
              slot     <= nx_slot;
              issue    <= nx_issue;
              bf_k     <= nx_k;
              iss_i0   <= nx_i0;
              iss_i1   <= nx_i1;
            end
          end
        end
        RUN: begin
          if (stage == 2'd2 && slot == 3'd4) begin
            state     <= OUT;
            stage     <= '0;
            slot      <= '0;
            out_valid <= 1'b1;
            out_idx   <= '0;
          end else begin
            stage  <= nx_stage;
            slot   <= nx_slot;
            issue  <= nx_issue;
            bf_k   <= nx_k;
            iss_i0 <= nx_i0;
            iss_i1 <= nx_i1;
          end
        end
        OUT: begin
          if (take) begin
            if (out_idx == 3'd7) begin
              state     <= LOAD;
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
              out_idx   <= '0;
            end else begin
              out_idx <= out_idx + 3'd1;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Working store carries no reset; every frame overwrites all 8 entries.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) begin
        store_re[load_addr] <= io.in_re;
        store_im[load_addr] <= io.in_im;
      end else if (wb_valid) begin
        store_re[wb_i0] <= DW'(bf_a0_re >>> 1);
        store_im[wb_i0] <= DW'(bf_a0_im >>> 1);
        store_re[wb_i1] <= DW'(bf_a1_re >>> 1);
        store_im[wb_i1] <= DW'(bf_a1_im >>> 1);
      end
    end
  end

  assign bf_x0_re = issue ? store_re[iss_i0] : '0;
  assign bf_x0_im = issue ? store_im[iss_i0] : '0;
  assign bf_x1_re = issue ? store_re[iss_i1] : '0;
  assign bf_x1_im = issue ? store_im[iss_i1] : '0;

  assign io.in_ready  = in_ready;
  assign io.out_valid = out_valid;
  assign io.out_idx   = out_idx;
  assign io.busy      = busy;
  assign io.out_re    = out_valid ? store_re[out_idx] : '0;
  assign io.out_im    = out_valid ? store_im[out_idx] : '0;

endmodule
